module_spi_rx_frame: RTL and testbench

- Parametrised SPI receive deserialiser for the SPI peripheral; successor to the fixed 8-bit MISO shift register.
- Samples miso_i on a one-cycle sample strobe (clk_fn_i) from the SPI clock generator, all within the clk_i domain.
- Counts bits and supports MSB-first or LSB-first order.
- Publishes only complete frames through a holding register with a valid/ack handshake and sticky overrun flag; partial frames are never visible.

---
 rtl/module_spi_rx_frame_pkg.sv | 16 +
 rtl/module_spi_rx_frame_bit_counter.sv | 39 +++
 rtl/module_spi_rx_frame.sv | 152 +++++++++++++++
 tb/tb_module_spi_rx_frame.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/module_spi_rx_frame_pkg.sv
// -----------------------------------------------------------------------------
// pkg_spi
// Shared types and constants for the SPI receive path.
//   spi_rx_state_t : receive FSM state encoding (IDLE, SHIFT)
//   SPI_DATA_W_DEF : default frame width in bits
// -----------------------------------------------------------------------------
package pkg_spi;

    localparam int SPI_DATA_W_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_rx_state_t;

endpackage : pkg_spi

// File: rtl/module_spi_rx_frame_bit_counter.sv
// -----------------------------------------------------------------------------
// module_spi_bit_counter
// Counts bits captured in the current SPI frame. It wraps to zero on the
// increment that lands on the last bit, so back-to-back frames need no gap.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-low reset
//   clr      synchronous clear; takes priority over inc
//   inc      count one captured bit
//   cnt      bits captured so far in this frame
//   terminal high while cnt == DATA_W-1 (the next inc completes a frame)
// -----------------------------------------------------------------------------
module module_spi_bit_counter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    assign terminal = (cnt == LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= terminal ? '0 : cnt + 1'b1;
        end
    end

endmodule : module_spi_bit_counter

// File: rtl/module_spi_rx_frame.sv
// -----------------------------------------------------------------------------
// module_spi_rx_frame
// Parametrised SPI receive deserialiser. MISO is sampled on a one-cycle strobe
// from the SPI clock generator while chip-select (en_i) is active. Only
// complete frames reach the holding register; a frame cut short by en_i
// dropping is discarded silently.
//
// State table
//   state | meaning
//   IDLE  | chip-select inactive, counter and shift register at zero
//   SHIFT | frame in progress, strobes shift bits in
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous active-low reset
//   en_i            frame active (chip-select level); low aborts the frame
//   clk_fn_i        one-cycle sample strobe
//   miso_i          serial data in
//   dato_ack_i      consumer has read dato_recibido_o
//   clr_ovr_i       clears overrun_o
//   dato_recibido_o last complete frame
//   dato_valido_o   holding register holds an unread frame
//   frame_done_o    one-cycle pulse per completed frame
//   overrun_o       sticky: a frame completed while the previous was unread
//   bit_cnt_o       bits captured in the current frame
// -----------------------------------------------------------------------------
module module_spi_rx_frame
    import pkg_spi::*;
#(
    parameter int DATA_W    = SPI_DATA_W_DEF,
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              clk_fn_i,
    input  logic              miso_i,
    input  logic              dato_ack_i,
    input  logic              clr_ovr_i,
    output logic [DATA_W-1:0] dato_recibido_o,
    output logic              dato_valido_o,
    output logic              frame_done_o,
    output logic              overrun_o,
    output logic [CNT_W-1:0]  bit_cnt_o
);

    spi_rx_state_t     state_q;
    spi_rx_state_t     state_d;
    logic              capture;
    logic              discard;
    logic              terminal;
    logic              complete;
    logic              ovr_set;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en_i)  state_d = SHIFT;
            SHIFT:   if (!en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A strobe in the same cycle en_i rises is already bit 0, so IDLE
    // captures too. Dropping en_i in SHIFT wins over a same-cycle strobe.
    always_comb begin
        capture = 1'b0;
        discard = 1'b0;
        unique case (state_q)
            IDLE:    capture = en_i & clk_fn_i;
            SHIFT: begin
                capture = en_i & clk_fn_i;
                discard = ~en_i;
            end
            default: discard = 1'b1;
        endcase
    end

    module_spi_bit_counter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_bit_counter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (discard),
        .inc      (capture),
        .cnt      (bit_cnt_o),
        .terminal (terminal)
    );

    assign complete = capture & terminal;
    // Overwriting an unread frame is an overrun unless the consumer acks
    // in the very same cycle.
    assign ovr_set  = complete & dato_valido_o & ~dato_ack_i;

    always_comb begin
        if (LSB_FIRST != 0) begin
            shreg_next = {miso_i, shreg_q[DATA_W-1:1]};
        end else begin
            shreg_next = {shreg_q[DATA_W-2:0], miso_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shreg_q <= '0;
        end else if (discard) begin
            shreg_q <= '0;
        end else if (capture) begin
            shreg_q <= shreg_next;
        end
    end

    // Holding register is loaded with shreg_next so the completing bit is
    // included without waiting a cycle for the shift register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dato_recibido_o <= '0;
            dato_valido_o   <= 1'b0;
            frame_done_o    <= 1'b0;
            overrun_o       <= 1'b0;
        end else begin
            frame_done_o <= complete;
            if (complete) begin
                dato_recibido_o <= shreg_next;
                dato_valido_o   <= 1'b1;
            end else if (dato_ack_i) begin
                dato_valido_o   <= 1'b0;
            end
            if (ovr_set) begin
                overrun_o <= 1'b1;
            end else if (clr_ovr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule : module_spi_rx_frame

// File: tb/tb_module_spi_rx_frame.sv
// Three receivers share one stimulus stream: 8-bit MSB-first, 8-bit
// LSB-first and 12-bit MSB-first. A frame-level model (bit queues, frame
// value assembled arithmetically on completion) predicts every output.
module tb_module_spi_rx_frame;

    localparam int N = 3;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic en_i = 1'b0, clk_fn_i = 1'b0, miso_i = 1'b0;
    logic dato_ack_i = 1'b0, clr_ovr_i = 1'b0;

    logic [7:0]  d0, d1;
    logic [11:0] d2;
    logic        v0, v1, v2, f0, f1, f2, o0, o1, o2;
    logic [3:0]  c0, c1, c2;

    always #5 clk_i = ~clk_i;

    module_spi_rx_frame #(.DATA_W(8), .LSB_FIRST(0)) u_msb8 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clk_fn_i(clk_fn_i),
        .miso_i(miso_i), .dato_ack_i(dato_ack_i), .clr_ovr_i(clr_ovr_i),
        .dato_recibido_o(d0), .dato_valido_o(v0), .frame_done_o(f0),
        .overrun_o(o0), .bit_cnt_o(c0));

    module_spi_rx_frame #(.DATA_W(8), .LSB_FIRST(1)) u_lsb8 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clk_fn_i(clk_fn_i),
        .miso_i(miso_i), .dato_ack_i(dato_ack_i), .clr_ovr_i(clr_ovr_i),
        .dato_recibido_o(d1), .dato_valido_o(v1), .frame_done_o(f1),
        .overrun_o(o1), .bit_cnt_o(c1));

    module_spi_rx_frame #(.DATA_W(12), .LSB_FIRST(0)) u_msb12 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clk_fn_i(clk_fn_i),
        .miso_i(miso_i), .dato_ack_i(dato_ack_i), .clr_ovr_i(clr_ovr_i),
        .dato_recibido_o(d2), .dato_valido_o(v2), .frame_done_o(f2),
        .overrun_o(o2), .bit_cnt_o(c2));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_w   [N] = '{8, 8, 12};
    bit          m_lsb [N] = '{1'b0, 1'b1, 1'b0};
    bit          bits_q[N][$];
    logic [31:0] m_data [N];
    bit          m_valid[N];
    bit          m_done [N];
    bit          m_ovr  [N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            bits_q[i].delete();
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
            m_done[i]  = 1'b0;
            m_ovr[i]   = 1'b0;
        end
    endtask

    task automatic model_step();
        bit          complete;
        bit          set_ovr;
        logic [31:0] val;
        for (int i = 0; i < N; i++) begin
            complete = 1'b0;
            val      = '0;
            if (!en_i) begin
                bits_q[i].delete();
            end else if (clk_fn_i) begin
                bits_q[i].push_back(miso_i);
                if (bits_q[i].size() == m_w[i]) begin
                    complete = 1'b1;
                    for (int k = 0; k < int'(m_w[i]); k++) begin
                        if (m_lsb[i]) val = val + (32'(bits_q[i][k]) << k);
                        else          val = val + (32'(bits_q[i][k]) << (int'(m_w[i]) - 1 - k));
                    end
                    bits_q[i].delete();
                end
            end
            set_ovr = complete && m_valid[i] && !dato_ack_i;
            if (complete) m_data[i] = val;
            if (complete)        m_valid[i] = 1'b1;
            else if (dato_ack_i) m_valid[i] = 1'b0;
            if (set_ovr)        m_ovr[i] = 1'b1;
            else if (clr_ovr_i) m_ovr[i] = 1'b0;
            m_done[i] = complete;
        end
    endtask

    task automatic check_all();
        logic [31:0] od, oc;
        logic        ov, of, oo;
        for (int i = 0; i < N; i++) begin
            case (i)
                0:       begin od = 32'(d0); ov = v0; of = f0; oo = o0; oc = 32'(c0); end
                1:       begin od = 32'(d1); ov = v1; of = f1; oo = o1; oc = 32'(c1); end
                default: begin od = 32'(d2); ov = v2; of = f2; oo = o2; oc = 32'(c2); end
            endcase
            chk($sformatf("data%0d", i),  od, m_data[i]);
            chk($sformatf("valid%0d", i), 32'(ov), 32'(m_valid[i]));
            chk($sformatf("done%0d", i),  32'(of), 32'(m_done[i]));
            chk($sformatf("ovr%0d", i),   32'(oo), 32'(m_ovr[i]));
            chk($sformatf("cnt%0d", i),   oc, 32'(bits_q[i].size()));
        end
    endtask

    // One clock: drive inputs, let DUT and model advance together, check.
    task automatic cyc(input bit e, input bit f, input bit m, input bit a, input bit c);
        en_i = e; clk_fn_i = f; miso_i = m; dato_ack_i = a; clr_ovr_i = c;
        @(posedge clk_i);
        model_step();
        #1;
        check_all();
    endtask

    // Sends n bits of v, most significant first, with random idle gaps
    // (miso toggling) before strobes; ack_last raises ack on the final strobe.
    task automatic send_bits(input logic [31:0] v, input int n, input bit ack_last);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) cyc(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0);
            cyc(1'b1, 1'b1, v[n-1-k], ack_last && (k == n - 1), 1'b0);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all();
        @(negedge clk_i);
        rst_i = 1'b1;

        // basic frame, both bit orders
        cyc(0, 0, 0, 0, 0);
        send_bits(32'hB4, 8, 1'b0);
        chk("msb_b4", 32'(d0), 32'hB4);
        chk("lsb_2d", 32'(d1), 32'h2D);
        chk("done_b4", 32'(f0), 32'd1);
        chk("valid_b4", 32'(v0), 32'd1);
        chk("ovr_b4", 32'(o0), 32'd0);
        cyc(0, 0, 0, 1, 0);
        chk("done_pulse_end", 32'(f0), 32'd0);

        // abort after 5 bits, then a full 0xFF frame
        send_bits(32'h1B, 5, 1'b0);
        cyc(0, 1, 1, 0, 0);
        chk("abort_cnt", 32'(c0), 32'd0);
        chk("abort_nodone", 32'(f0), 32'd0);
        send_bits(32'hFF, 8, 1'b0);
        chk("after_abort_ff", 32'(d0), 32'hFF);

        // back-to-back without ack -> overrun
        cyc(0, 0, 0, 1, 1);
        send_bits(32'h12, 8, 1'b0);
        send_bits(32'h34, 8, 1'b0);
        chk("b2b_ovr", 32'(o0), 32'd1);
        chk("b2b_data", 32'(d0), 32'h34);
        cyc(1, 0, 0, 0, 1);
        chk("ovr_clr", 32'(o0), 32'd0);

        // back-to-back with ack on the second completion -> no overrun
        cyc(0, 0, 0, 1, 1);
        send_bits(32'h12, 8, 1'b0);
        send_bits(32'h34, 8, 1'b1);
        chk("ack_ovr", 32'(o0), 32'd0);
        chk("ack_valid", 32'(v0), 32'd1);

        // asynchronous reset mid-frame with valid set
        cyc(0, 0, 0, 0, 0);
        send_bits(32'h5, 3, 1'b0);
        #2;
        rst_i = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_valid", 32'(v0), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        cyc(0, 0, 0, 0, 0);
        send_bits(32'hA5, 8, 1'b0);
        chk("post_rst_a5", 32'(d0), 32'hA5);

        // 12-bit frame
        cyc(0, 0, 0, 1, 1);
        send_bits(32'hABC, 12, 1'b0);
        chk("w12_abc", 32'(d2), 32'hABC);
        chk("w12_cnt_wrap", 32'(c2), 32'd0);

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            cyc(($urandom % 40) != 0, 1'($urandom), 1'($urandom),
                ($urandom % 8) == 0, ($urandom % 16) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_module_spi_rx_frame
